// File: rtl/mult_lane_scheduler.sv
// mult_lane_scheduler
//   Shares the three pipe-stage-2 multiplier lanes among NREQ requesters.
//   The lane rotates 0->1->2 on every enabled cycle. At most one requester
//   is granted per cycle, chosen round-robin. Each issue is tracked through a
//   LAT-deep in-flight record, so every completing product is reported with
//   the requester and lane it belongs to.
//
//   Optional feature macro: REQ0_PRIORITY_EN
//     defined   : req[0] always wins; requesters 1..NREQ-1 round-robin
//                 among themselves, and ptr is left alone on a req[0] grant.
//     undefined : pure round-robin across all NREQ requesters.
//
// Ports
//   clk          rising-edge clock
//   start        asynchronous active-high reset, clears all state
//   enable       scheduler runs when 1
//   req          per-requester request, level-held until granted
//   grant        one-hot grant, combinational, same cycle as req
//   lane         current lane index 0..2
//   p2_En        lane pair enable, 0 when nothing is granted
//   s2_Muxes     operand select, follows lane
//   res_valid    a product completes this cycle
//   res_tag      requester of the completing product (0 when idle)
//   res_lane     lane of the completing product (0 when idle)
//   busy         at least one product in flight
//   issue_count  grants since reset, wraps modulo 2^16
module mult_lane_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  parameter int unsigned TAGW = 2
) (
  input  logic            clk,
  input  logic            start,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      lane,
  output logic [5:0]      p2_En,
  output logic [3:0]      s2_Muxes,
  output logic            res_valid,
  output logic [TAGW-1:0] res_tag,
  output logic [1:0]      res_lane,
  output logic            busy,
  output logic [15:0]     issue_count
);

  logic [1:0]                r_lane;
  logic [TAGW-1:0]           r_ptr;
  logic [15:0]               r_cnt;
  logic [LAT-1:0]            r_vld;
  logic [LAT-1:0][TAGW-1:0]  r_tag;
  logic [LAT-1:0][1:0]       r_rlane;

  logic [NREQ-1:0]           w_grant;
  logic [NREQ-1:0]           w_rr_req;
  logic [TAGW-1:0]           w_gidx;
  logic                      w_found;
  logic                      w_upd_ptr;

  // Index k steps after the last granted requester, wrapping at NREQ.
  function automatic logic [TAGW-1:0] rr_index(input logic [TAGW-1:0] p,
                                               input int unsigned k);
    int unsigned s;
    s = (int'(p) + k) % NREQ;
    return s[TAGW-1:0];
  endfunction

  always_comb begin
    w_grant   = '0;
    w_gidx    = '0;
    w_found   = 1'b0;
    w_upd_ptr = 1'b0;
`ifdef REQ0_PRIORITY_EN
    // Requester 0 is taken out of the rotation and checked first.
    w_rr_req  = req & ~NREQ'(1);
`else
    w_rr_req  = req;
`endif
    if (!start && enable) begin
`ifdef REQ0_PRIORITY_EN
      if (req[0]) begin
        w_grant[0] = 1'b1;
        w_found    = 1'b1;
      end
`endif
      for (int unsigned k = 1; k <= NREQ; k++) begin
        if (!w_found && w_rr_req[rr_index(r_ptr, k)]) begin
          w_found   = 1'b1;
          w_upd_ptr = 1'b1;
          w_gidx    = rr_index(r_ptr, k);
          w_grant[rr_index(r_ptr, k)] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      r_lane  <= '0;
      r_ptr   <= TAGW'(NREQ - 1);
      r_cnt   <= '0;
      r_vld   <= '0;
      r_tag   <= '0;
      r_rlane <= '0;
    end else begin
      if (enable)
        r_lane <= (r_lane == 2'd2) ? 2'd0 : r_lane + 2'd1;
      if (w_upd_ptr)
        r_ptr <= w_gidx;
      if (w_found)
        r_cnt <= r_cnt + 16'd1;
      // The in-flight record shifts every edge so products drain even
      // while the scheduler is disabled.
      r_vld[0]   <= w_found;
      r_tag[0]   <= w_found ? w_gidx : '0;
      r_rlane[0] <= w_found ? r_lane : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_tag[i]   <= r_tag[i-1];
        r_rlane[i] <= r_rlane[i-1];
      end
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    s2_Muxes = 4'b0000;
      2'd1:    s2_Muxes = 4'b1100;
      default: s2_Muxes = 4'b0011;
    endcase
    p2_En = 6'b000000;
    if (w_found) begin
      case (r_lane)
        2'd0:    p2_En = 6'b110000;
        2'd1:    p2_En = 6'b001100;
        default: p2_En = 6'b000011;
      endcase
    end
  end

  assign grant       = w_grant;
  assign lane        = r_lane;
  assign issue_count = r_cnt;
  assign res_valid   = r_vld[LAT-1];
  assign res_tag     = r_vld[LAT-1] ? r_tag[LAT-1]   : '0;
  assign res_lane    = r_vld[LAT-1] ? r_rlane[LAT-1] : '0;
  assign busy        = |r_vld;

endmodule
